// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, LSB-first payload,
// one-cycle valid / frame-error / break pulses and a held copy of the last good payload.
module uart_rx #(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_HZ       = 120_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_busy
);

  localparam int unsigned BIT_P          = 1_000_000_000 / BIT_RATE;
  localparam int unsigned CLK_P          = 1_000_000_000 / CLK_HZ;
  localparam int unsigned CYCLES_PER_BIT = BIT_P / CLK_P;
  localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CYCLES_PER_BIT / 2);
  localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic                    rxd_m_q, rxd_s_q;
  logic [1:0]              sync_vld_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    stop_low_q, stop_low_d;
  logic                    armed_q, armed_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    stop_low_d = stop_low_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    brk_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A start is only accepted after a genuine high has been seen on the line,
        // so a line stuck low (after reset or a break) never produces frames.
        if (rxd_s_q && sync_vld_q[1]) armed_d = 1'b1;
        if (uart_rx_en && armed_q && !rxd_s_q) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d                     = '0;
          shift_d                   = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1]   = rxd_s_q;
          bit_cnt_d                 = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_DATA) begin
            state_d    = STOP;
            bit_cnt_d  = '0;
            stop_low_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d      = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          stop_low_d = stop_low_q | ~rxd_s_q;
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (stop_low_q || !rxd_s_q) begin
              ferr_d  = 1'b1;
              brk_d   = (shift_q == '0);
              armed_d = 1'b0;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
              armed_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rxd_m_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      sync_vld_q <= '0;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      stop_low_q <= 1'b0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_m_q    <= uart_rxd;
      rxd_s_q    <= rxd_m_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      stop_low_q <= stop_low_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_break     = brk_q;
  assign uart_rx_busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_RATE, default 115200, line bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 120_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame (1..8).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1..2).
REQ-005 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port uart_rx_en, input, 1, receive enable; sampled only in IDLE.
REQ-009 SHALL have port uart_rx_valid, output, 1, one-cycle pulse: new frame on uart_rx_data.
REQ-010 SHALL have port uart_rx_data, output, PAYLOAD_BITS, last good received payload.
REQ-011 SHALL have port uart_rx_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port uart_rx_break, output, 1, one-cycle pulse: all data and stop samples low.
REQ-013 SHALL have port uart_rx_busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-014 SHALL compute CYCLES_PER_BIT = (1e9/BIT_RATE)/(1e9/CLK_HZ) in integer ns arithmetic (1085 at defaults); bit period = CYCLES_PER_BIT+1 clocks, matching uart_tx.
REQ-015 SHALL pass uart_rxd through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxd_s.
REQ-016 SHALL use cycle counter of width 1+clog2(CYCLES_PER_BIT), cleared on every state change and on each sample point.
REQ-017 SHALL implement states IDLE, START, DATA, STOP.
REQ-018 IDLE -> START when uart_rx_en=1 and rxd_s=0; otherwise stay IDLE.
REQ-019 START: at counter == CYCLES_PER_BIT/2 (542) sample rxd_s; 0 -> DATA, 1 -> IDLE (glitch, no outputs pulsed).
REQ-020 DATA: sample at counter == CYCLES_PER_BIT; shift sample into MSB of shift register (LSB-first line order); after PAYLOAD_BITS samples -> STOP.
REQ-021 STOP: sample at counter == CYCLES_PER_BIT; record any low sample; after STOP_BITS samples -> IDLE.
REQ-022 On final stop sample with all stop samples high: load uart_rx_data from shift register and pulse uart_rx_valid the next cycle.
REQ-023 On final stop sample with any stop sample low: pulse uart_rx_frame_err next cycle; uart_rx_data unchanged; no valid pulse.
REQ-024 If additionally all payload samples were 0: pulse uart_rx_break in the same cycle as uart_rx_frame_err.
REQ-025 uart_rx_data SHALL hold its value until the next good frame; never changes without uart_rx_valid.
REQ-026 Deasserting uart_rx_en mid-frame SHALL NOT abort the frame; it only blocks new start detection.
REQ-027 Back-to-back frames: a start edge in the cycle after returning to IDLE SHALL be accepted.

Reset
REQ-028 reset=1 SHALL immediately force: FSM IDLE, counters 0, shift register 0, uart_rx_data 0, valid/frame_err/break/busy 0, synchronizer flops 1.
REQ-029 reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts only on a new falling edge seen while rxd_s is high-then-low.
REQ-030 After reset release with uart_rxd held low, the block SHALL NOT report a frame until the line goes high and then low again.

Verification
REQ-031 Drive 0xA5, 8N1 at defaults via uart_tx model -> one uart_rx_valid pulse, uart_rx_data=0xA5, no frame_err/break.
REQ-032 Send 0x00,0xFF,0x55 back-to-back with no idle gap -> three valid pulses, data 0x00, 0xFF, 0x55 in order.
REQ-033 Low glitch of 100 clocks on idle line -> FSM returns IDLE, no output pulses, busy high for ~544 cycles only.
REQ-034 Frame 0x3C with stop bit forced low -> frame_err pulse, no valid, uart_rx_data keeps previous value.
REQ-035 Line held low for 12 bit periods -> break and frame_err pulse together, then no further frame until line returns high.
REQ-036 Assert reset at data bit 4 of 0x81, release, send 0x42 -> only one valid pulse, data=0x42.
